ksa: RTL and testbench

- Key-scheduling stage of the ARC4 datapath. Runs after s_mem has been filled with the identity permutation (s[i]=i).
- Reads s_mem, accumulates j, and swaps s[i] and s[j] for i = 0..255 using the supplied key.
- Exposes the same en/rdy start handshake and the same single-port s_mem master interface as the fill stage. The top-level FSM can sequence fill -> ksa -> prga on one shared memory port.

---
 rtl/arc4_pkg.sv | 22 ++
 rtl/arc4_key_sel.sv | 25 ++
 rtl/ksa.sv | 140 ++++++++++++++
 tb/tb_ksa.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 datapath stages (fill, ksa, prga).
// No ports: imported with "import arc4_pkg::*".
package arc4_pkg;

    // Key-scheduling controller states.
    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        LD_I,
        RD_J,
        LD_J,
        WR_I,
        WR_J
    } ksa_state_t;

    // Number of entries in the ARC4 state array s_mem.
    localparam int S_LEN = 256;

    // Default ARC4 key width in bits (three key bytes).
    localparam int ARC4_KEY_W = 24;

endpackage

// File: rtl/arc4_key_sel.sv
// Combinational key-byte selector shared by the ksa and prga stages.
// Byte 0 is the most significant byte of the key vector.
// Ports:
//   key   : in  [8*KEY_BYTES-1:0] key vector
//   idx   : in  [IDX_W-1:0]       byte index, 0..KEY_BYTES-1
//   kbyte : out [7:0]             selected key byte (0 for an out-of-range index)
module arc4_key_sel #(
    parameter int KEY_BYTES = 3,
    parameter int IDX_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [IDX_W-1:0]       idx,
    output logic [7:0]             kbyte
);

    always_comb begin
        kbyte = 8'h00;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (idx == IDX_W'(b)) begin
                kbyte = key[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

endmodule

// File: rtl/ksa.sv
// ARC4 key-scheduling stage. Assumes s_mem already holds the identity
// permutation and performs, for i = 0..255:
//   j = j + s[i] + key[i mod KEY_BYTES]; swap(s[i], s[j])
// over a single-port synchronous memory (read data valid one cycle after the
// address is presented).
// Ports:
//   clk    : in  clock
//   rst_n  : in  synchronous active-low reset
//   en     : in  start request, sampled only while rdy=1
//   rdy    : out idle and ready to accept en
//   key    : in  [8*KEY_BYTES-1:0] key, latched on acceptance
//   addr   : out [7:0] s_mem address
//   rddata : in  [7:0] s_mem read data
//   wrdata : out [7:0] s_mem write data
//   wren   : out s_mem write enable
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for en; no memory access
// RD_I  | present addr=i for read
// LD_I  | capture si, accumulate j with s[i] and the current key byte
// RD_J  | present addr=j for read
// LD_J  | capture sj
// WR_I  | write sj to s[i]
// WR_J  | write si to s[j]; finish after i==255, else advance i
module ksa
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = ARC4_KEY_W / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
);

    localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    ksa_state_t             state, state_nx;
    logic [7:0]             i, j, si, sj;
    logic [KIW-1:0]         ki;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [7:0]             kb;

    wire start    = (state == IDLE) && en;
    wire last_i   = (i == 8'(S_LEN - 1));
    wire ki_last  = (ki == KIW'(KEY_BYTES - 1));

    arc4_key_sel #(
        .KEY_BYTES (KEY_BYTES),
        .IDX_W     (KIW)
    ) u_key_sel (
        .key   (key_q),
        .idx   (ki),
        .kbyte (kb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = RD_I;
            RD_I:    state_nx = LD_I;
            LD_I:    state_nx = RD_J;
            RD_J:    state_nx = LD_J;
            LD_J:    state_nx = WR_I;
            WR_I:    state_nx = WR_J;
            WR_J:    state_nx = last_i ? IDLE : RD_I;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i     <= '0;
            j     <= '0;
            si    <= '0;
            sj    <= '0;
            ki    <= '0;
            key_q <= '0;
        end else begin
            if (start) begin
                i     <= '0;
                j     <= '0;
                ki    <= '0;
                key_q <= key;
            end
            if (state == LD_I) begin
                si <= rddata;
                j  <= j + rddata + kb;
            end
            if (state == LD_J) begin
                sj <= rddata;
            end
            // The i==255 case leaves i wrapping to 0, which is harmless
            // because the next run clears it again on acceptance.
            if (state == WR_J) begin
                i  <= i + 8'd1;
                ki <= ki_last ? '0 : ki + 1'b1;
            end
        end
    end

    // Memory interface decoded from registered state only.
    always_comb begin
        addr   = 8'h00;
        wrdata = 8'h00;
        wren   = 1'b0;
        case (state)
            RD_I: addr = i;
            RD_J: addr = j;
            WR_I: begin
                addr   = i;
                wrdata = sj;
                wren   = 1'b1;
            end
            WR_J: begin
                addr   = j;
                wrdata = si;
                wren   = 1'b1;
            end
            default: ;
        endcase
    end

    assign rdy = (state == IDLE);

endmodule

// File: tb/tb_ksa.sv
module tb_ksa;

    localparam int KB = 3;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [23:0] key = 24'h0;
    logic        rdy;
    logic [7:0]  addr;
    logic [7:0]  rddata;
    logic [7:0]  wrdata;
    logic        wren;

    always #5 clk = ~clk;

    ksa #(.KEY_BYTES(KB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .rdy    (rdy),
        .key    (key),
        .addr   (addr),
        .rddata (rddata),
        .wrdata (wrdata),
        .wren   (wren)
    );

    // Single-port synchronous s_mem; init_req reloads the identity permutation.
    logic [7:0] mem [256];
    bit         init_req = 1'b0;

    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (wren) begin
            mem[addr] <= wrdata;
        end
        rddata <= mem[addr];
    end

    int  checks   = 0;
    int  failures = 0;
    int  wr_count = 0;
    int  run_w0   = 0;
    int  model_s [256];
    wr_t exp_q [$];
    wr_t wlog  [$];
    wr_t mon_e;

    // Monitor: every write the DUT presents is popped against the scoreboard.
    always @(negedge clk) begin
        if (wren === 1'b1) begin
            wr_count++;
            wlog.push_back({addr, wrdata});
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected got addr=%02h data=%02h, expected no write",
                         addr, wrdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.a !== addr || mon_e.d !== wrdata) begin
                    failures++;
                    $display("FAIL write_seq got addr=%02h data=%02h, expected addr=%02h data=%02h",
                             addr, wrdata, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference key schedule: produces the expected write stream and the
    // resulting permutation in model_s.
    task automatic model_run(input logic [23:0] k);
        int jj = 0;
        int kbv, t;
        for (int ii = 0; ii < 256; ii++) begin
            kbv = int'((k >> (8 * (KB - 1 - (ii % KB)))) & 24'hFF);
            jj  = (jj + model_s[ii] + kbv) % 256;
            exp_q.push_back({8'(ii), 8'(model_s[jj])});
            exp_q.push_back({8'(jj), 8'(model_s[ii])});
            t           = model_s[ii];
            model_s[ii] = model_s[jj];
            model_s[jj] = t;
        end
    endtask

    task automatic init_mem();
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        for (int k = 0; k < 256; k++) model_s[k] = k;
    endtask

    task automatic check_mem(input string nm);
        int bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (mem[k] !== 8'(model_s[k])) bad++;
        end
        chk(nm, bad, 0);
    endtask

    // Call at a negedge while the DUT is idle; the next posedge is cycle 0.
    task automatic set_start(input logic [23:0] k);
        chk("rdy_before_start", int'(rdy), 1);
        key    = k;
        en     = 1'b1;
        model_run(k);
        run_w0 = wr_count;
        wlog.delete();
    endtask

    task automatic start_run(input logic [23:0] k);
        @(negedge clk);
        set_start(k);
    endtask

    // Walks cycles 1..1537 after acceptance checking the busy window.
    task automatic wait_run(input bit release_en, input bit pulse);
        int busy_bad = 0;
        for (int c = 1; c <= 1537; c++) begin
            @(negedge clk);
            if (c == 1 && release_en) en = 1'b0;
            if (pulse && c == 300) en = 1'b0;
            if (pulse && c == 302) en = 1'b1;
            if (c == 50) key = 24'($urandom);
            if (c <= 1536) begin
                if (rdy !== 1'b0) busy_bad++;
            end else begin
                chk("rdy_at_1537", int'(rdy), 1);
            end
        end
        chk("rdy_high_while_busy", busy_bad, 0);
        chk("writes_per_run", wr_count - run_w0, 512);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic chk_w(input string nm, input int idx, input int a, input int d);
        int act = -1;
        if (idx < wlog.size()) act = int'({wlog[idx].a, wlog[idx].d});
        chk(nm, act, (a << 8) | d);
    endtask

    initial begin
        // Reset and idle behaviour
        repeat (2) @(negedge clk);
        chk("reset_rdy", int'(rdy), 1);
        chk("reset_wren", int'(wren), 0);
        chk("reset_addr", int'(addr), 0);
        chk("reset_wrdata", int'(wrdata), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_no_writes", wr_count, 0);
        chk("idle_rdy", int'(rdy), 1);

        // Key 00033C on identity memory
        init_mem();
        start_run(24'h00033C);
        wait_run(1'b1, 1'b0);
        chk_w("k33c_i0_w0", 0, 8'h00, 8'h00);
        chk_w("k33c_i0_w1", 1, 8'h00, 8'h00);
        chk_w("k33c_i1_w0", 2, 8'h01, 8'h04);
        chk_w("k33c_i1_w1", 3, 8'h04, 8'h01);
        chk_w("k33c_i2_w0", 4, 8'h02, 8'h42);
        chk_w("k33c_i2_w1", 5, 8'h42, 8'h02);
        check_mem("k33c_final_mem");

        // Key 000000: self-swaps at i=0 and i=1
        init_mem();
        start_run(24'h000000);
        wait_run(1'b1, 1'b0);
        chk_w("k0_i0_w0", 0, 8'h00, 8'h00);
        chk_w("k0_i0_w1", 1, 8'h00, 8'h00);
        chk_w("k0_i1_w0", 2, 8'h01, 8'h01);
        chk_w("k0_i1_w1", 3, 8'h01, 8'h01);
        chk_w("k0_i2_w0", 4, 8'h02, 8'h03);
        chk_w("k0_i2_w1", 5, 8'h03, 8'h02);
        check_mem("k0_final_mem");

        // en held high with a mid-run pulse; back-to-back second run
        init_mem();
        start_run(24'h00033C);
        wait_run(1'b0, 1'b1);
        set_start(24'h00033C);
        wait_run(1'b1, 1'b0);
        check_mem("twice_final_mem");

        // Reset at cycle 700 aborts the run
        init_mem();
        start_run(24'($urandom));
        for (int c = 1; c <= 700; c++) begin
            @(negedge clk);
            if (c == 1) en = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rdy", int'(rdy), 1);
        chk("abort_wren", int'(wren), 0);
        chk("abort_addr", int'(addr), 0);
        chk("abort_writes_done", wr_count - run_w0, 232);
        chk("abort_pending_writes", exp_q.size(), 280);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_more_writes", wr_count - run_w0, 232);
        exp_q.delete();

        init_mem();
        start_run(24'($urandom));
        wait_run(1'b1, 1'b0);
        check_mem("post_abort_final_mem");

        // Random keys chained on the permuted memory
        for (int r = 0; r < 2; r++) begin
            start_run(24'($urandom));
            wait_run(1'b1, 1'b0);
            check_mem("random_final_mem");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
